// File: rtl/nn_pkg.sv
// Shared types and sizing constants for the activation datapath.
package nn_pkg;

    localparam int SYS_ARRAY_WIDTH = 15;
    localparam int LUT_A_WID       = 15;

    typedef logic [15:0] lane_t;
    typedef lane_t [SYS_ARRAY_WIDTH-1:0] lane_vec_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        HOLD
    } seq_state_t;

endpackage

// File: rtl/sigmoid_addr_map.sv
// Maps a signed Q8.8 pre-activation onto the sigmoid LUT address space.
module sigmoid_addr_map
    import nn_pkg::*;
#(
    parameter int A_WID = LUT_A_WID
) (
    input  lane_t              x_i,
    output logic [A_WID-1:0]   addr_o
);

    // Flipping the sign bit turns two's complement into offset binary, so the
    // most negative input lands on address 0 and the table is monotonic.
    assign addr_o = {~x_i[15], x_i[14:16-A_WID]};

    generate
        if (A_WID < 16) begin : gDropLow
            logic unusedLowBits;
            assign unusedLowBits = ^x_i[15-A_WID:0];
        end
    endgenerate

endmodule

// File: rtl/sigmoid_lut_sequencer.sv
// Streams one activation vector through the shared sigmoid LUT BRAM, one lane
// per cycle, and arbitrates LUT preload writes against lookups.
module sigmoid_lut_sequencer
    import nn_pkg::*;
#(
    parameter int A_WID           = LUT_A_WID,
    parameter int SYS_ARRAY_WIDTH = nn_pkg::SYS_ARRAY_WIDTH
) (
    input  logic                          clk_i,
    input  logic                          reset_i,

    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  lane_t [SYS_ARRAY_WIDTH-1:0]   in_data_i,

    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output lane_t [SYS_ARRAY_WIDTH-1:0]   out_data_o,

    input  logic                          cfg_valid_i,
    output logic                          cfg_ready_o,
    input  logic [A_WID-1:0]              cfg_addr_i,
    input  lane_t [SYS_ARRAY_WIDTH-1:0]   cfg_data_i,

    output logic                          bram_en_o,
    output logic                          bram_we_o,
    output logic [A_WID-1:0]              bram_addr_o,
    output lane_t [SYS_ARRAY_WIDTH-1:0]   bram_di_o,
    input  lane_t [SYS_ARRAY_WIDTH-1:0]   bram_dout_i
);

    localparam int CNT_W = (SYS_ARRAY_WIDTH > 1) ? $clog2(SYS_ARRAY_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(SYS_ARRAY_WIDTH - 1);

    seq_state_t                    state_q, state_d;
    logic [CNT_W-1:0]              lane_cnt_q, lane_cnt_d;
    logic                          out_valid_q, out_valid_d;
    lane_t [SYS_ARRAY_WIDTH-1:0]   x_q;
    lane_t [SYS_ARRAY_WIDTH-1:0]   out_data_q;
    logic                          cap_valid_q;
    logic [CNT_W-1:0]              cap_lane_q;
    logic [A_WID-1:0]              addr_q;
    lane_t [SYS_ARRAY_WIDTH-1:0]   di_q;

    logic                          inFire;
    logic                          lastLane;
    logic [A_WID-1:0]              laneAddr;

    // A pending cfg write always wins the IDLE cycle, so inputs wait behind it.
    assign inFire   = (state_q == IDLE) && in_valid_i && !cfg_valid_i;
    assign lastLane = (lane_cnt_q == LAST_LANE);

    sigmoid_addr_map #(
        .A_WID (A_WID)
    ) uAddrMap (
        .x_i    (x_q[lane_cnt_q]),
        .addr_o (laneAddr)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            lane_cnt_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_cnt_q  <= lane_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lane_cnt_d  = lane_cnt_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (inFire) begin
                    state_d    = ISSUE;
                    lane_cnt_d = '0;
                end
            end
            ISSUE: begin
                if (lastLane) begin
                    state_d    = DRAIN;
                    lane_cnt_d = '0;
                end else begin
                    lane_cnt_d = lane_cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                state_d     = HOLD;
                out_valid_d = 1'b1;
            end
            HOLD: begin
                if (out_ready_i) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Address and write data fall back to their registered copies so the BRAM
    // pins hold steady whenever nothing is being accessed.
    always_comb begin
        in_ready_o  = 1'b0;
        cfg_ready_o = 1'b0;
        bram_en_o   = 1'b0;
        bram_we_o   = 1'b0;
        bram_addr_o = addr_q;
        bram_di_o   = di_q;
        case (state_q)
            IDLE: begin
                cfg_ready_o = 1'b1;
                in_ready_o  = !cfg_valid_i;
                if (cfg_valid_i) begin
                    bram_en_o   = 1'b1;
                    bram_we_o   = 1'b1;
                    bram_addr_o = cfg_addr_i;
                    bram_di_o   = cfg_data_i;
                end
            end
            ISSUE: begin
                bram_en_o   = 1'b1;
                bram_addr_o = laneAddr;
            end
            default: ;
        endcase
    end

    // The BRAM answers one cycle after the read, so the issued lane index is
    // delayed by one cycle to steer the capture.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            x_q         <= '0;
            out_data_q  <= '0;
            cap_valid_q <= 1'b0;
            cap_lane_q  <= '0;
            addr_q      <= '0;
            di_q        <= '0;
        end else begin
            addr_q      <= bram_addr_o;
            di_q        <= bram_di_o;
            cap_valid_q <= (state_q == ISSUE);
            cap_lane_q  <= lane_cnt_q;
            if (inFire) begin
                x_q <= in_data_i;
            end
            if (cap_valid_q) begin
                out_data_q[cap_lane_q] <= bram_dout_i[cap_lane_q];
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

endmodule
